sdp_y_alu_op_pack: RTL
======================

SDP_Y_ALU_OP_PACK -- requirements
Module: sdp_y_alu_op_pack

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: nvdla_core_clk is the single clock and nvdla_core_rst is the reset.
REQ-002 SHALL have no parameters; widths are fixed by package constants ELEM_W=16, LANES=8, WORD_W=128, DEPTH=2.
REQ-003 SHALL have these ports:
- nvdla_core_clk  in  1  clock
- nvdla_core_rst  in  1  sync active-high reset
- alu_in_pvld  in  1  element valid
- alu_in_prdy  out  1  element ready
- alu_in_pd  in  16  ALU operand element
- alu_in_last  in  1  element closes current word
- chn_alu_op_rsc_z  out  128  packed operand word
- chn_alu_op_rsc_vz  out  1  word valid
- chn_alu_op_rsc_lz  in  1  consumer load; word consumed when vz&&lz
- pack_idle  out  1  no partial word and FIFO empty

Function
REQ-004 SHALL accept an element when alu_in_pvld && alu_in_prdy.
REQ-005 SHALL drive alu_in_prdy = (fifo_count < DEPTH), from registered state only, with no combinational path from chn_alu_op_rsc_lz.
REQ-006 SHALL place the k-th accepted element of a word (k=0..7) in bits [16k+15:16k], using a lane counter lane_idx in 0..7.
REQ-007 SHALL complete a word when the accepted element has lane_idx==7 or alu_in_last==1.
- Lanes above the final lane are zero.
- The completed word (assembly register merged with the incoming element) is pushed to the FIFO in the same cycle.
- lane_idx returns to 0 and the assembly register clears.
REQ-008 SHALL otherwise increment lane_idx and hold the element in the assembly register.
REQ-009 SHALL keep a 2-entry FIFO.
- chn_alu_op_rsc_z is the head entry; chn_alu_op_rsc_vz = (fifo_count != 0).
- A pop occurs on vz&&lz.
REQ-010 SHALL handle push and pop in the same cycle as follows:
- fifo_count is unchanged.
- Order is preserved.
- This can only occur at count 1, since REQ-005 blocks a push at count 2.
REQ-011 SHALL keep z stable while vz is high and lz is low.
REQ-012 SHALL give a word whose last element is accepted in cycle N vz=1 in cycle N+1 when the FIFO was empty.
REQ-013 SHALL drive pack_idle = (lane_idx==0) && (fifo_count==0).
REQ-014 SHALL treat a single element with alu_in_last=1 at lane 0 as a full word containing only lane 0.
REQ-015 SHALL wrap fifo read and write pointers modulo 2.

Reset
REQ-016 SHALL set the following in the cycle after nvdla_core_rst is sampled high:
- lane_idx=0
- assembly register=0
- fifo_count=0
- pointers=0
- vz=0
- alu_in_prdy=1 (may be asserted during reset)
- pack_idle=1
- z=0
REQ-017 SHALL discard any partial word and all FIFO contents on a reset asserted mid-operation, with no word emitted afterward.
REQ-018 SHALL ignore alu_in_pvld and chn_alu_op_rsc_lz while reset is high.

Structure
REQ-019 SHALL place ELEM_W, LANES, WORD_W, DEPTH and the lane-index typedef in shared package sdp_y_alu_op_pkg.
REQ-020 SHALL implement the 2-entry buffer as sub-module sdp_y_alu_op_fifo2 (push, pop, data, count); the packer logic lives in the top.

Verification
REQ-021 SHALL cover the scenarios below:
- Full word: elements 0x0001..0x0008 back-to-back, lz=1 -> one word z=0x0008_0007_0006_0005_0004_0003_0002_0001, vz one cycle after 8th accept.
- Partial word: 0xAAAA,0xBBBB with last on 2nd -> z=0x…0000_BBBB_AAAA (upper 96 bits zero); lane_idx back to 0.
- Backpressure: lz=0, stream 24 elements -> two words buffered, prdy drops after 16th accept, z holds word0; raise lz -> words in order, prdy returns next cycle.
- Simultaneous push/pop at count 1 -> count stays 1, no data loss or duplication across 10 words.
- Reset mid-word after 5 elements plus 1 buffered word -> vz=0, pack_idle=1 next cycle; next 8 elements produce a clean word.
- Single-element last at lane 0 with pd=0x1234 -> z=0x…0000_1234.

Source files
------------

// File: rtl/sdp_y_alu_op_pkg.sv
// Shared constants and types for the SDP Y-path ALU operand packer.
// ELEM_W : width of one ALU operand element
// LANES  : elements per packed word
// WORD_W : packed word width (ELEM_W * LANES)
// DEPTH  : output buffer depth in words
package sdp_y_alu_op_pkg;

  localparam int ELEM_W     = 16;
  localparam int LANES      = 8;
  localparam int WORD_W     = 128;
  localparam int DEPTH      = 2;
  localparam int LANE_IDX_W = 3;
  localparam int CNT_W      = 2;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;
  typedef logic [CNT_W-1:0]      fifo_cnt_t;
  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [ELEM_W-1:0]     elem_t;

endpackage

// File: rtl/sdp_y_alu_op_pack_if.sv
// Element-in / word-out bus of the ALU operand packer.
// alu_in_*          : element stream (valid/ready, data, end-of-word marker)
// chn_alu_op_rsc_*  : packed word stream (z data, vz valid, lz consumer load)
// slave  : packer side
// master : producer/consumer side
interface sdp_y_alu_op_pack_if;
  import sdp_y_alu_op_pkg::*;

  logic  alu_in_pvld;
  logic  alu_in_prdy;
  elem_t alu_in_pd;
  logic  alu_in_last;
  word_t chn_alu_op_rsc_z;
  logic  chn_alu_op_rsc_vz;
  logic  chn_alu_op_rsc_lz;

  modport slave (
    input  alu_in_pvld,
    input  alu_in_pd,
    input  alu_in_last,
    input  chn_alu_op_rsc_lz,
    output alu_in_prdy,
    output chn_alu_op_rsc_z,
    output chn_alu_op_rsc_vz
  );

  modport master (
    output alu_in_pvld,
    output alu_in_pd,
    output alu_in_last,
    output chn_alu_op_rsc_lz,
    input  alu_in_prdy,
    input  chn_alu_op_rsc_z,
    input  chn_alu_op_rsc_vz
  );

endinterface

// File: rtl/sdp_y_alu_op_fifo2.sv
// Two-entry word buffer for the ALU operand packer.
// clk, rst  : clock, synchronous active-high reset
// push/wr_data : write one word (caller guarantees count < DEPTH)
// pop       : drop the head word (caller guarantees count != 0)
// rd_data   : head word, held stable until popped
// count     : number of stored words (0..2)
module sdp_y_alu_op_fifo2
  import sdp_y_alu_op_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  word_t     wr_data,
  output word_t     rd_data,
  output fifo_cnt_t count
);

  word_t     mem [DEPTH];
  logic      wr_ptr;
  logic      rd_ptr;
  fifo_cnt_t cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // push and pop together leave the occupancy unchanged
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + fifo_cnt_t'(1);
        2'b01:   cnt_q <= cnt_q - fifo_cnt_t'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign count   = cnt_q;

endmodule

// File: rtl/sdp_y_alu_op_pack.sv
// ALU operand packer: collects 16-bit elements into 128-bit words
// (element k of a word in bits [16k+15:16k]) and buffers up to two
// finished words for the downstream consumer.
// nvdla_core_clk : clock
// nvdla_core_rst : synchronous active-high reset
// bus            : element input and packed word output (slave side)
// pack_idle      : no partial word assembled and buffer empty
module sdp_y_alu_op_pack
  import sdp_y_alu_op_pkg::*;
(
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  sdp_y_alu_op_pack_if.slave  bus,
  output logic                pack_idle
);

  lane_idx_t lane_idx;
  word_t     asm_q;
  word_t     merged;
  fifo_cnt_t fifo_count;
  logic      accept;
  logic      word_done;
  logic      pop;

  // Ready depends only on the registered occupancy, so there is no path
  // from the consumer load back to the element ready.
  assign bus.alu_in_prdy       = (fifo_count < fifo_cnt_t'(DEPTH));
  assign bus.chn_alu_op_rsc_vz = (fifo_count != '0);

  assign accept    = bus.alu_in_pvld && bus.alu_in_prdy && !nvdla_core_rst;
  assign word_done = accept &&
                     ((lane_idx == lane_idx_t'(LANES - 1)) || bus.alu_in_last);
  assign pop       = bus.chn_alu_op_rsc_vz && bus.chn_alu_op_rsc_lz && !nvdla_core_rst;

  // Lanes above the current one are still zero in asm_q, so a word closed
  // early by alu_in_last comes out zero-filled without extra masking.
  always_comb begin
    merged = asm_q;
    for (int k = 0; k < LANES; k++) begin
      if (lane_idx == lane_idx_t'(k)) begin
        merged[k*ELEM_W +: ELEM_W] = bus.alu_in_pd;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      lane_idx <= '0;
      asm_q    <= '0;
    end else if (word_done) begin
      lane_idx <= '0;
      asm_q    <= '0;
    end else if (accept) begin
      lane_idx <= lane_idx + lane_idx_t'(1);
      asm_q    <= merged;
    end
  end

  sdp_y_alu_op_fifo2 u_fifo (
    .clk     (nvdla_core_clk),
    .rst     (nvdla_core_rst),
    .push    (word_done),
    .pop     (pop),
    .wr_data (merged),
    .rd_data (bus.chn_alu_op_rsc_z),
    .count   (fifo_count)
  );

  assign pack_idle = (lane_idx == '0) && (fifo_count == '0);

endmodule
